// File: rtl/ps2_host_tx_ctrl_pkg.sv
// Shared definitions for the PS/2 host-to-device transmit path:
// controller states, frame geometry and default 50 MHz cycle constants.
package ps2_host_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_RTS     = 3'd2,
    ST_XFER    = 3'd3,
    ST_ACK     = 3'd4
  } ps2_tx_state_e;

  // Frame as held in the shift register: {stop, parity, data[7:0], start}
  localparam int unsigned FRAME_LEN          = 11;
  localparam int unsigned EDGE_CNT_W         = 4;
  // Falling edge that puts the stop bit on the line; the next edge is the ACK.
  localparam int unsigned LAST_DATA_EDGE     = 10;

  // 100 us clock inhibit and 15 ms transfer timeout at 50 MHz
  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_host_tx_ctrl_sync2.sv
// Two-flop synchronizer with a parameterized reset level, used for the
// raw PS/2 data pin so its latency matches the clock edge detector.
module ps2_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic D_In,
  output logic Q_Out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state values: a plain two-stage shift
  always_comb begin
    meta_d = D_In;
    sync_d = meta_q;
  end

  // Synchronizer flops, released to the idle line level
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign Q_Out = sync_q;

endmodule

// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device transmit controller: inhibits the clock, issues a
// request-to-send, shifts out start/data/parity/stop on device clock
// falling edges, then checks the device ACK, with an overall timeout.
module ps2_host_tx_ctrl
  import ps2_host_tx_ctrl_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       H2L_Sig,
  input  logic       PS2_DAT_In,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_Data,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_Err
);

  localparam int unsigned INH_W = cnt_width(INHIBIT_CYCLES);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);

  localparam logic [INH_W-1:0]      INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [EDGE_CNT_W-1:0] EDGE_LAST = EDGE_CNT_W'(LAST_DATA_EDGE);

  ps2_tx_state_e         state_q, state_d;
  logic [INH_W-1:0]      inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [FRAME_LEN-1:0]  frame_q, frame_d;
  logic                  clk_oe_q, clk_oe_d;
  logic                  dat_oe_q, dat_oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  dat_sync;
  logic [EDGE_CNT_W-1:0] edge_next;
  logic                  timed_out;

  ps2_sync2 #(
    .RESET_VAL (1'b1)
  ) u_dat_sync (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .D_In  (PS2_DAT_In),
    .Q_Out (dat_sync)
  );

  // Next-state, counter and registered-output logic for the transmit sequence
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    edge_cnt_d = edge_cnt_q;
    frame_d    = frame_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    edge_next  = edge_cnt_q + EDGE_CNT_W'(1);
    timed_out  = (to_cnt_q == TO_LAST);

    unique case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        if (Tx_Start) begin
          // Bit 0 is the start bit so edge k simply drives frame[k].
          frame_d    = {1'b1, ~^Tx_Data, Tx_Data, 1'b0};
          inh_cnt_d  = '0;
          to_cnt_d   = '0;
          edge_cnt_d = '0;
          clk_oe_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          dat_oe_d = ~frame_q[0];
          state_d  = ST_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      ST_RTS: begin
        clk_oe_d   = 1'b0;
        edge_cnt_d = '0;
        to_cnt_d   = '0;
        state_d    = ST_XFER;
      end

      ST_XFER: begin
        if (timed_out) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (H2L_Sig) begin
            edge_cnt_d = edge_next;
            dat_oe_d   = ~frame_q[edge_next];
            if (edge_next == EDGE_LAST) begin
              state_d = ST_ACK;
            end
          end
        end
      end

      ST_ACK: begin
        dat_oe_d = 1'b0;
        if (timed_out) begin
          clk_oe_d = 1'b0;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (H2L_Sig) begin
            done_d  = ~dat_sync;
            err_d   = dat_sync;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, counters, frame and outputs; reset releases both lines at once
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      edge_cnt_q <= '0;
      frame_q    <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      frame_q    <= frame_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign PS2_CLK_OE = clk_oe_q;
  assign PS2_DAT_OE = dat_oe_q;
  assign Tx_Busy    = busy_q;
  assign Tx_Done    = done_q;
  assign Tx_Err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Scoreboard bench for ps2_host_tx_ctrl: a behavioural PS/2 device drives
// falling edges and ACK, expected outcomes are queued at stimulus time and
// a negedge monitor pops and compares them when Done/Err appear.
module tb_ps2_host_tx_ctrl;

  localparam int INH = 20;
  localparam int TO  = 2000;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       H2L_Sig = 1'b0;
  logic       Tx_Start = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       dev_dat = 1'b1;
  logic       PS2_DAT_In;
  logic       PS2_CLK_OE, PS2_DAT_OE, Tx_Busy, Tx_Done, Tx_Err;

  // Open-collector data line: low if either side pulls it
  assign PS2_DAT_In = dev_dat & ~PS2_DAT_OE;

  ps2_host_tx_ctrl #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .H2L_Sig    (H2L_Sig),
    .PS2_DAT_In (PS2_DAT_In),
    .Tx_Start   (Tx_Start),
    .Tx_Data    (Tx_Data),
    .PS2_CLK_OE (PS2_CLK_OE),
    .PS2_DAT_OE (PS2_DAT_OE),
    .Tx_Busy    (Tx_Busy),
    .Tx_Done    (Tx_Done),
    .Tx_Err     (Tx_Err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        is_err;
    int        nbits;
    bit [10:0] bits;
  } exp_t;

  exp_t      exp_q[$];
  bit [10:0] obs;
  int        obs_n = 0;
  int        pulses = 0;
  int        pulse_cyc = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Line levels the device should see: start 0, data LSB first, odd parity, stop 1
  function automatic bit [10:0] ref_bits(input logic [7:0] d);
    bit [10:0] b;
    int ones;
    ones = 0;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i+1] = d[i];
      ones += int'(d[i]);
    end
    b[9]  = ((ones % 2) == 0);
    b[10] = 1'b1;
    return b;
  endfunction

  // Monitor: pop the expected outcome whenever a Done/Err pulse appears
  always @(negedge CLK) begin
    exp_t e;
    if (Tx_Done && Tx_Err) begin
      checks++;
      errors++;
      $display("FAIL done_err_together actual=both_high required=exclusive (t=%0t)", $time);
    end
    if (Tx_Done || Tx_Err) begin
      pulses++;
      pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=done%0d_err%0d required=no_pulse (t=%0t)",
                 Tx_Done, Tx_Err, $time);
      end else begin
        e = exp_q.pop_front();
        chk("outcome_err", int'(Tx_Err), int'(e.is_err));
        chk("outcome_done", int'(Tx_Done), int'(!e.is_err));
        chk("bits_seen", obs_n, e.nbits);
        for (int i = 0; i < e.nbits && i < 11; i++)
          chk($sformatf("frame_bit%0d", i), int'(obs[i]), int'(e.bits[i]));
        chk("busy_after_pulse", int'(Tx_Busy), 0);
        chk("clk_oe_after_pulse", int'(PS2_CLK_OE), 0);
        chk("dat_oe_after_pulse", int'(PS2_DAT_OE), 0);
      end
    end
  end

  // One host transmission with the device model.  nedges < 11 stops the
  // device early (timeout); poke_edge issues a start mid-transfer;
  // rst_edge pulls reset during that falling-edge pulse.
  task automatic send(input logic [7:0] d, input bit ack, input int nedges,
                      input int poke_edge, input int rst_edge);
    exp_t e;
    int   c, clk_hi, dat_rise, rel, p0;
    p0    = pulses;
    obs_n = 0;
    obs   = '0;
    @(negedge CLK);
    Tx_Data  = d;
    Tx_Start = 1'b1;
    if (rst_edge == 0) begin
      e.is_err = (nedges < 11) ? 1'b1 : ack;
      e.nbits  = (nedges < 11) ? nedges : 11;
      e.bits   = ref_bits(d);
      exp_q.push_back(e);
    end
    @(negedge CLK);
    Tx_Start = 1'b0;
    Tx_Data  = 8'($urandom);
    chk("busy_rise", int'(Tx_Busy), 1);
    clk_hi   = 0;
    dat_rise = 0;
    c        = 1;
    while (PS2_CLK_OE && c < 100) begin
      clk_hi++;
      if (PS2_DAT_OE && dat_rise == 0) dat_rise = c;
      @(negedge CLK);
      c++;
    end
    chk("clk_oe_hold_cycles", clk_hi, INH + 1);
    chk("dat_oe_rise_cycle", dat_rise, INH + 1);
    rel = cyc;
    for (int k = 0; k < nedges; k++) begin
      repeat ($urandom_range(2, 5)) @(negedge CLK);
      if (k < 11) begin
        obs[k] = PS2_DAT_In;
        obs_n++;
      end
      if (k == 10) begin
        dev_dat = ack;
        repeat (4) @(negedge CLK);
      end
      if (k == poke_edge) begin
        Tx_Data  = 8'h12;
        Tx_Start = 1'b1;
        @(negedge CLK);
        Tx_Start = 1'b0;
      end
      H2L_Sig = 1'b1;
      if (k + 1 == rst_edge) begin
        RSTn = 1'b0;
        #1;
        chk("rst_clk_oe", int'(PS2_CLK_OE), 0);
        chk("rst_dat_oe", int'(PS2_DAT_OE), 0);
        chk("rst_busy", int'(Tx_Busy), 0);
      end
      @(negedge CLK);
      H2L_Sig = 1'b0;
      dev_dat = 1'b1;
      if (k + 1 == rst_edge) begin
        RSTn = 1'b1;
        repeat (40) @(negedge CLK);
        chk("no_pulse_after_reset", pulses - p0, 0);
        chk("idle_after_reset", int'(PS2_CLK_OE), 0);
        return;
      end
    end
    c = 0;
    while (pulses == p0 && c < TO + 200) begin
      @(negedge CLK);
      c++;
    end
    chk("pulse_arrived", pulses - p0, 1);
    if (nedges < 11) chk("timeout_latency", pulse_cyc - rel, TO);
    repeat (5) @(negedge CLK);
    chk("idle_clk_oe", int'(PS2_CLK_OE), 0);
    chk("idle_busy", int'(Tx_Busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_clk_oe", int'(PS2_CLK_OE), 0);
    chk("reset_dat_oe", int'(PS2_DAT_OE), 0);
    chk("reset_busy", int'(Tx_Busy), 0);
    chk("reset_done", int'(Tx_Done), 0);
    chk("reset_err", int'(Tx_Err), 0);
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);

    send(8'h55, 1'b0, 11, -1, 0);
    send(8'h01, 1'b0, 11, -1, 0);
    send(8'hFF, 1'b0, 11, -1, 0);
    send(8'hA3, 1'b1, 11, -1, 0);
    send(8'($urandom), 1'b0, 4, -1, 0);
    send(8'hC7, 1'b0, 11, 3, 0);
    send(8'($urandom), 1'b0, 11, -1, 6);
    send(8'h3C, 1'b0, 11, -1, 0);
    for (int n = 0; n < 6; n++)
      send(8'($urandom), 1'($urandom_range(0, 1)), 11, -1, 0);

    repeat (10) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
